// File: rtl/calc_kb_pkg.sv
// Shared key codes, receiver states and the set-2 scan-code lookup for the
// calculator keyboard front end.
package calc_kb_pkg;

    typedef logic [4:0] key_t;

    localparam key_t KEY_0     = 5'd0;
    localparam key_t KEY_1     = 5'd1;
    localparam key_t KEY_2     = 5'd2;
    localparam key_t KEY_3     = 5'd3;
    localparam key_t KEY_4     = 5'd4;
    localparam key_t KEY_5     = 5'd5;
    localparam key_t KEY_6     = 5'd6;
    localparam key_t KEY_7     = 5'd7;
    localparam key_t KEY_8     = 5'd8;
    localparam key_t KEY_9     = 5'd9;
    localparam key_t KEY_ADD   = 5'd10;
    localparam key_t KEY_SUB   = 5'd11;
    localparam key_t KEY_MUL   = 5'd12;
    localparam key_t KEY_DIV   = 5'd13;
    localparam key_t KEY_ENTER = 5'd14;
    localparam key_t KEY_BKSP  = 5'd15;
    localparam key_t KEY_CLR   = 5'd16;
    localparam key_t KEY_NONE  = 5'd31;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    // Translate a scan byte (with the E0 prefix flag) into a calculator key.
    function automatic key_t map_scan(input logic ext, input logic [7:0] scan);
        key_t k;
        k = KEY_NONE;
        if (ext) begin
            case (scan)
                8'h4A:   k = KEY_DIV;
                8'h5A:   k = KEY_ENTER;
                default: k = KEY_NONE;
            endcase
        end else begin
            case (scan)
                8'h45, 8'h70: k = KEY_0;
                8'h16, 8'h69: k = KEY_1;
                8'h1E, 8'h72: k = KEY_2;
                8'h26, 8'h7A: k = KEY_3;
                8'h25, 8'h6B: k = KEY_4;
                8'h2E, 8'h73: k = KEY_5;
                8'h36, 8'h74: k = KEY_6;
                8'h3D, 8'h6C: k = KEY_7;
                8'h3E, 8'h75: k = KEY_8;
                8'h46, 8'h7D: k = KEY_9;
                8'h79:        k = KEY_ADD;
                8'h7B, 8'h4E: k = KEY_SUB;
                8'h7C:        k = KEY_MUL;
                8'h4A:        k = KEY_DIV;
                8'h5A:        k = KEY_ENTER;
                8'h66:        k = KEY_BKSP;
                8'h76:        k = KEY_CLR;
                default:      k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, the
// start/data/parity/stop state machine and an inactivity watchdog that drops
// partial frames.
module ps2_rx
    import calc_kb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sync_clk;
    logic                   sync_clk_q;
    logic                   sync_data;
    logic                   fall;

    rx_state_t       state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par;
    logic [WD_W-1:0] wd;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign fall      = sync_clk_q & ~sync_clk;

    // Bring the idle-high keyboard lines into the clk domain; reset to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            sync_clk_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            sync_clk_q <= sync_clk;
        end
    end

    // Frame state machine with watchdog; byte_vld/frame_err are 1-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RX_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            wd        <= '0;
            byte_vld  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (state == RX_IDLE) begin
                wd <= '0;
                if (fall) begin
                    if (!sync_data) begin
                        state  <= RX_DATA;
                        bitcnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (fall) begin
                wd <= '0;
                case (state)
                    RX_DATA: begin
                        shreg  <= {sync_data, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= RX_PAR;
                    end
                    RX_PAR: begin
                        par   <= sync_data;
                        state <= RX_STOP;
                    end
                    default: begin
                        // Odd parity over data+parity and a high stop bit.
                        if ((^{shreg, par}) && sync_data) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                endcase
            end else if (wd == WD_LAST) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
                wd        <= '0;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives set-2 frames and tracks the held
// calculator key, the last key pressed, and make/break prefixes.
module ps2_key_decoder
    import calc_kb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [4:0] key_code,
    output logic [4:0] last_key,
    output logic       key_strobe,
    output logic       frame_err
);

    logic       byte_vld;
    logic [7:0] rx_byte;
    logic       ext;
    logic       brk;
    key_t       code;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_data (PS2_DATA),
        .byte_vld (byte_vld),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

    assign code = map_scan(ext, rx_byte);

    // Prefix handling and held/last key tracking on each received byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code   <= KEY_NONE;
            last_key   <= KEY_NONE;
            key_strobe <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_vld) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (code != KEY_NONE) begin
                        if (!brk) begin
                            key_code   <= code;
                            last_key   <= code;
                            key_strobe <= 1'b1;
                        end else if (code == key_code) begin
                            key_code <= KEY_NONE;
                        end
                    end
                end
            end
        end
    end

endmodule
